// File: rtl/cdb_pkg.sv
// cdb_pkg: shared constants for the common data bus and its arbiter.
//   CDB_DATA_W / CDB_TAG_W : bus payload and source-tag widths
//   arb_state_e            : arbiter FSM state encoding
//   NO_GRANT               : grant_idx value when nothing is granted
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_TAG_W  = 6;
  localparam int NO_GRANT   = 0;

  typedef enum logic [1:0] {
    ARB_STATE_IDLE  = 2'd0,
    ARB_STATE_GRANT = 2'd1,
    ARB_STATE_GUARD = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   i_req     : request vector, one bit per unit
//   i_ptr     : last served unit; scan starts at i_ptr+1 (mod NUM_UNITS)
//   o_onehot  : one-hot winner (0 when no request)
//   o_idx     : winner index (0 when no request)
//   o_any_req : any request bit set
module rr_pick #(
  parameter  int NUM_UNITS = 4,
  localparam int IW        = $clog2(NUM_UNITS)
) (
  input  logic [NUM_UNITS-1:0] i_req,
  input  logic [IW-1:0]        i_ptr,
  output logic [NUM_UNITS-1:0] o_onehot,
  output logic [IW-1:0]        o_idx,
  output logic                 o_any_req
);

  logic          w_found;
  logic [IW-1:0] w_j;

  assign o_any_req = |i_req;

  // First hit wins; offsets 1..NUM_UNITS so the last-served unit is checked last.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    w_j      = '0;
    for (int k = 1; k <= NUM_UNITS; k++) begin
      w_j = IW'((int'(i_ptr) + k) % NUM_UNITS);
      if (!w_found && i_req[w_j]) begin
        w_found       = 1'b1;
        o_onehot[w_j] = 1'b1;
        o_idx         = w_j;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of the common data bus to functional units.
// Each grant holds CDB_xmit for HOLD_CYCLES cycles, then one GUARD cycle
// with no grant before the next arbitration.
//   clock, reset_n  : clock, synchronous active-low reset
//   CDB_rts         : per-unit request-to-send (level)
//   CDB_write       : bus write strobe (monitor only)
//   CDB_xmit        : one-hot grant
//   grant_valid     : any xmit bit high
//   grant_idx       : granted unit index, 0 when idle
//   bus_busy        : high in GRANT and GUARD
//   protocol_error  : sticky, write seen with no grant
// Optional macro CDB_ARB_STARVE_CHECK_EN adds MAX_WAIT, starve_error and
// starve_idx (per-unit wait counters, sticky lowest starving unit).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int NUM_UNITS   = 4,
  parameter  int HOLD_CYCLES = 1,
`ifdef CDB_ARB_STARVE_CHECK_EN
  parameter  int MAX_WAIT    = 16,
`endif
  localparam int IW          = $clog2(NUM_UNITS)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_UNITS-1:0] CDB_rts,
  input  logic                 CDB_write,
  output logic [NUM_UNITS-1:0] CDB_xmit,
  output logic                 grant_valid,
  output logic [IW-1:0]        grant_idx,
  output logic                 bus_busy,
`ifdef CDB_ARB_STARVE_CHECK_EN
  output logic                 starve_error,
  output logic [IW-1:0]        starve_idx,
`endif
  output logic                 protocol_error
);

  localparam int HW = 4;

  arb_state_e           r_state, w_state_nxt;
  logic [IW-1:0]        r_ptr, w_ptr_nxt;
  logic [HW-1:0]        r_hold, w_hold_nxt;
  logic [NUM_UNITS-1:0] r_xmit, w_xmit_nxt;
  logic [IW-1:0]        r_gidx, w_gidx_nxt;
  logic                 r_perr;

  logic [NUM_UNITS-1:0] w_onehot;
  logic [IW-1:0]        w_idx;
  logic                 w_any;

  rr_pick #(.NUM_UNITS(NUM_UNITS)) u_pick (
    .i_req    (CDB_rts),
    .i_ptr    (r_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_any_req(w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    w_xmit_nxt  = r_xmit;
    w_gidx_nxt  = r_gidx;
    case (r_state)
      ARB_STATE_IDLE, ARB_STATE_GUARD: begin
        if (w_any) begin
          w_state_nxt = ARB_STATE_GRANT;
          w_xmit_nxt  = w_onehot;
          w_gidx_nxt  = w_idx;
          w_hold_nxt  = HW'(HOLD_CYCLES - 1);
        end else begin
          w_state_nxt = ARB_STATE_IDLE;
          w_xmit_nxt  = '0;
          w_gidx_nxt  = IW'(NO_GRANT);
        end
      end
      ARB_STATE_GRANT: begin
        // rts is ignored here: a dropped request never shortens the grant.
        if (r_hold == '0) begin
          w_state_nxt = ARB_STATE_GUARD;
          w_xmit_nxt  = '0;
          w_gidx_nxt  = IW'(NO_GRANT);
          w_ptr_nxt   = r_gidx;
        end else begin
          w_hold_nxt = r_hold - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ARB_STATE_IDLE;
        w_xmit_nxt  = '0;
        w_gidx_nxt  = IW'(NO_GRANT);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= ARB_STATE_IDLE;
      r_ptr   <= IW'(NUM_UNITS - 1);
      r_hold  <= '0;
      r_xmit  <= '0;
      r_gidx  <= '0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_hold  <= w_hold_nxt;
      r_xmit  <= w_xmit_nxt;
      r_gidx  <= w_gidx_nxt;
      r_perr  <= r_perr | (CDB_write & ~(|r_xmit));
    end
  end

  assign CDB_xmit       = r_xmit;
  assign grant_valid    = |r_xmit;
  assign grant_idx      = r_gidx;
  assign bus_busy       = (r_state != ARB_STATE_IDLE);
  assign protocol_error = r_perr;

`ifdef CDB_ARB_STARVE_CHECK_EN
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [NUM_UNITS-1:0][WW-1:0] r_wait, w_wait_nxt;
  logic [NUM_UNITS-1:0]         w_hit;
  logic [IW-1:0]                w_hit_idx;
  logic                         r_serr;
  logic [IW-1:0]                r_sidx;

  // Counters saturate at MAX_WAIT so a long wait cannot wrap past the threshold.
  always_comb begin
    w_wait_nxt = '0;
    w_hit      = '0;
    w_hit_idx  = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (CDB_rts[i] && !r_xmit[i])
        w_wait_nxt[i] = (r_wait[i] == WW'(MAX_WAIT)) ? r_wait[i] : r_wait[i] + 1'b1;
      w_hit[i] = (w_wait_nxt[i] == WW'(MAX_WAIT));
    end
    for (int i = NUM_UNITS - 1; i >= 0; i--)
      if (w_hit[i]) w_hit_idx = IW'(i);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_wait <= '0;
      r_serr <= 1'b0;
      r_sidx <= '0;
    end else begin
      r_wait <= w_wait_nxt;
      if (!r_serr && |w_hit) begin
        r_serr <= 1'b1;
        r_sidx <= w_hit_idx;
      end
    end
  end

  assign starve_error = r_serr;
  assign starve_idx   = r_sidx;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

  localparam int N = 4;
`ifdef CDB_ARB_STARVE_CHECK_EN
  localparam int NI = 3;
`else
  localparam int NI = 2;
`endif
  localparam int HOLD_T [3] = '{1, 3, 15};
  localparam int MW_T   [3] = '{16, 16, 4};

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] rts [3];
  logic       wr  [3];
  logic [3:0] xm  [3];
  logic       gv  [3];
  logic [1:0] gi  [3];
  logic       bb  [3];
  logic       pe  [3];
  logic       se  [3];
  logic [1:0] si  [3];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    cdb_arbiter #(
      .NUM_UNITS  (N),
`ifdef CDB_ARB_STARVE_CHECK_EN
      .MAX_WAIT   (MW_T[g]),
`endif
      .HOLD_CYCLES(HOLD_T[g])
    ) u_dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .CDB_rts       (rts[g]),
      .CDB_write     (wr[g]),
      .CDB_xmit      (xm[g]),
      .grant_valid   (gv[g]),
      .grant_idx     (gi[g]),
      .bus_busy      (bb[g]),
`ifdef CDB_ARB_STARVE_CHECK_EN
      .starve_error  (se[g]),
      .starve_idx    (si[g]),
`endif
      .protocol_error(pe[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, act, exp);
    end
  endtask

  // Model: bus occupancy expressed as cycles left of grant+guard.
  // bl>1 means granted to cur, bl==1 is the guard cycle, 0 is idle.
  int  bl   [3];
  int  cur  [3];
  int  last [3];
  bit  mperr[3];
  int  wcnt [3][4];
  bit  mse  [3];
  int  msi  [3];

  function automatic int exp_x(int i);
    return (bl[i] > 1) ? (1 << cur[i]) : 0;
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < NI; i++) begin
      if (!reset_n) begin
        bl[i] = 0; cur[i] = 0; last[i] = N - 1; mperr[i] = 0;
        mse[i] = 0; msi[i] = 0;
        for (int u = 0; u < N; u++) wcnt[i][u] = 0;
      end else begin
        int px;
        bit done;
        px = exp_x(i);
        if (wr[i] && px == 0) mperr[i] = 1;
        for (int u = 0; u < N; u++)
          wcnt[i][u] = (rts[i][u] && !px[u]) ? wcnt[i][u] + 1 : 0;
        if (!mse[i]) begin
          done = 0;
          for (int u = 0; u < N; u++)
            if (!done && wcnt[i][u] == MW_T[i]) begin mse[i] = 1; msi[i] = u; done = 1; end
        end
        if (bl[i] > 1) begin
          bl[i]--;
          if (bl[i] == 1) last[i] = cur[i];
        end else if (rts[i] != 0) begin
          done = 0;
          for (int k = 1; k <= N; k++) begin
            int u;
            u = (last[i] + k) % N;
            if (!done && rts[i][u]) begin cur[i] = u; done = 1; end
          end
          bl[i] = HOLD_T[i] + 1;
        end else begin
          bl[i] = 0;
        end
      end
    end
  end

  // Compare process: every cycle, every instance.
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("xmit%0d", i), int'(xm[i]), exp_x(i));
      chk($sformatf("gvalid%0d", i), int'(gv[i]), int'(bl[i] > 1));
      chk($sformatf("gidx%0d", i), int'(gi[i]), (bl[i] > 1) ? cur[i] : 0);
      chk($sformatf("busy%0d", i), int'(bb[i]), int'(bl[i] > 0));
      chk($sformatf("perr%0d", i), int'(pe[i]), int'(mperr[i]));
`ifdef CDB_ARB_STARVE_CHECK_EN
      chk($sformatf("serr%0d", i), int'(se[i]), int'(mse[i]));
      chk($sformatf("sidx%0d", i), int'(si[i]), msi[i]);
`endif
    end
  end

  task automatic cyc();
    @(posedge clock); #2;
  endtask

  initial begin
    int exp_a [9];
    int xh_b, bb_b;
    exp_a = '{1, 0, 2, 0, 4, 0, 8, 0, 1};
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin rts[i] = '0; wr[i] = 1'b0; end
    rts[0] = 4'b1111; rts[1] = 4'b0010; rts[2] = 4'b0011;
    repeat (3) cyc();
    chk("lit_reset_xmit", int'(xm[0]), 0);
    chk("lit_reset_busy", int'(bb[0]), 0);
    @(negedge clock) reset_n = 1'b1;
    cyc();
    chk("lit_first_xmit", int'(xm[0]), 1);
    chk("lit_first_gidx", int'(gi[0]), 0);
    chk("lit_hold3_xmit", int'(xm[1]), 2);
    xh_b = 1; bb_b = 1;
    @(negedge clock) rts[1] = 4'b0000;
    for (int c = 1; c <= 8; c++) begin
      cyc();
      chk($sformatf("lit_rr_c%0d", c), int'(xm[0]), exp_a[c]);
      if (xm[1][1]) xh_b++;
      if (bb[1]) bb_b++;
    end
    chk("lit_hold3_len", xh_b, 3);
    chk("lit_hold3_busy", bb_b, 4);
`ifdef CDB_ARB_STARVE_CHECK_EN
    chk("lit_starve_err", int'(se[2]), 1);
    chk("lit_starve_idx", int'(si[2]), 1);
`endif
    // Single requester on unit 2.
    @(negedge clock) rts[0] = 4'b0100;
    cyc();
    chk("lit_single_guard", int'(xm[0]), 0);
    cyc();
    chk("lit_single_x1", int'(xm[0]), 4);
    chk("lit_single_idx", int'(gi[0]), 2);
    cyc();
    chk("lit_single_gap", int'(xm[0]), 0);
    cyc();
    chk("lit_single_x2", int'(xm[0]), 4);
    // All zero: nothing granted.
    @(negedge clock) rts[0] = 4'b0000;
    repeat (4) cyc();
    chk("lit_zero_xmit", int'(xm[0]), 0);
    chk("lit_zero_busy", int'(bb[0]), 0);
    // Write with no grant on A; write during a grant on B.
    @(negedge clock) begin wr[0] = 1'b1; rts[1] = 4'b0001; end
    cyc();
    @(negedge clock) begin wr[0] = 1'b0; wr[1] = 1'b1; end
    cyc();
    chk("lit_perr_set", int'(pe[0]), 1);
    @(negedge clock) begin wr[1] = 1'b0; rts[1] = 4'b0000; end
    repeat (3) cyc();
    chk("lit_perr_sticky", int'(pe[0]), 1);
    chk("lit_perr_granted", int'(pe[1]), 0);
    @(negedge clock) reset_n = 1'b0;
    cyc();
    chk("lit_perr_clear", int'(pe[0]), 0);
    @(negedge clock) reset_n = 1'b1;
    repeat (2) cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
